// File: rtl/rv32i_types.sv
// Shared RV32I types plus the 2-bit branch-predictor counter type and its encodings.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  // 2-bit saturating direction counter; the MSB is the predicted direction.
  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t CTR_SNT = 2'b00;  // strongly not-taken
  localparam bp_ctr_t CTR_WNT = 2'b01;  // weakly not-taken
  localparam bp_ctr_t CTR_WT  = 2'b10;  // weakly taken
  localparam bp_ctr_t CTR_ST  = 2'b11;  // strongly taken

endpackage

// File: rtl/sat_counter2.sv
// Next-value function of a 2-bit saturating counter. It is shared by the gshare
// and local predictors.
module sat_counter2
  import rv32i_types::*;
(
  input  bp_ctr_t cur,
  input  logic    taken,
  output bp_ctr_t nxt
);

  // Count toward the outcome and stop at the strong states.
  always_comb begin
    // NOTE: nxt gets a default first, so every path assigns it and no latch is inferred.
    nxt = cur;
    if (taken && (cur != CTR_ST)) begin
      nxt = cur + 2'd1;
    end else if (!taken && (cur != CTR_SNT)) begin
      nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor. The PHT of 2-bit counters is indexed by
// PC[HIST_BITS+1:2] XOR the speculative GHR. The lookup path is combinational.
// Training and GHR repair happen when the branch resolves in EX.
module gshare_predictor
  import rv32i_types::*;
#(
  parameter int      HIST_BITS = 8,
  parameter bp_ctr_t CTR_INIT  = CTR_WNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  rv32i_word            if_pc,
  input  logic                 lookup_valid,
  output logic                 global_prediction,
  output logic [HIST_BITS-1:0] pred_index,
  output logic [HIST_BITS-1:0] pred_ghr,
  input  logic                 upd_valid,
  input  logic [HIST_BITS-1:0] upd_index,
  input  logic [HIST_BITS-1:0] upd_ghr,
  input  logic                 upd_taken,
  input  logic                 upd_mispredict
);

  localparam int PHT_DEPTH = 2 ** HIST_BITS;

  logic [HIST_BITS-1:0] ghr;
  bp_ctr_t              pht [PHT_DEPTH];
  logic [HIST_BITS-1:0] lookup_idx;
  bp_ctr_t              upd_ctr_nxt;

  // Only the word-aligned PC bits that feed the index matter here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:HIST_BITS+2], if_pc[1:0]};

  // Lookup: PHT reads come straight from the flops, so a same-cycle update is not bypassed.
  assign lookup_idx        = if_pc[HIST_BITS+1:2] ^ ghr;
  assign pred_index        = lookup_idx;
  assign pred_ghr          = ghr;
  assign global_prediction = pht[lookup_idx][1];

  sat_counter2 u_upd_ctr (
    .cur   (pht[upd_index]),
    .taken (upd_taken),
    .nxt   (upd_ctr_nxt)
  );

  // Speculative history: a mispredict repair takes priority over the fetch-side shift.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every reader sees the pre-edge value.
    if (rst) begin
      ghr <= '0;
    end else if (upd_valid && upd_mispredict) begin
      ghr <= {upd_ghr[HIST_BITS-2:0], upd_taken};
    end else if (lookup_valid) begin
      ghr <= {ghr[HIST_BITS-2:0], global_prediction};
    end
  end

  // PHT training: at most one write per cycle, to upd_index only.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the PHT is built from flops, not a RAM macro, so every entry is reset in the same cycle.
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht[i] <= CTR_INIT;
      end
    end else if (upd_valid) begin
      pht[upd_index] <= upd_ctr_nxt;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor with HIST_BITS = 8. Expected lookup
// outputs come from a behavioural model. They are queued when the stimulus is
// driven and compared when the DUT outputs have settled.
module tb_gshare_predictor;

  import rv32i_types::*;

  localparam int HB = 8;

  logic           clk = 1'b0;
  logic           rst;
  rv32i_word      if_pc;
  logic           lookup_valid;
  logic           global_prediction;
  logic [HB-1:0]  pred_index;
  logic [HB-1:0]  pred_ghr;
  logic           upd_valid;
  logic [HB-1:0]  upd_index;
  logic [HB-1:0]  upd_ghr;
  logic           upd_taken;
  logic           upd_mispredict;

  gshare_predictor #(.HIST_BITS(HB), .CTR_INIT(2'b01)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_pc             (if_pc),
    .lookup_valid      (lookup_valid),
    .global_prediction (global_prediction),
    .pred_index        (pred_index),
    .pred_ghr          (pred_ghr),
    .upd_valid         (upd_valid),
    .upd_index         (upd_index),
    .upd_ghr           (upd_ghr),
    .upd_taken         (upd_taken),
    .upd_mispredict    (upd_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [HB-1:0] idx;
    logic          pred;
    logic [HB-1:0] ghr;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  logic [HB-1:0] m_ghr;
  logic [1:0]    m_pht [256];

  // Outputs observed in the most recent cycle, used for the directed checks.
  logic          obs_pred;
  logic [HB-1:0] obs_idx;
  logic [HB-1:0] obs_ghr;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
    else   return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  // One clock of stimulus. The model is advanced at the edge that follows.
  task automatic cycle(input logic r, input logic [31:0] pc, input logic lv,
                       input logic uv, input logic [HB-1:0] ui, input logic [HB-1:0] ug,
                       input logic ut, input logic um);
    exp_t e;
    exp_t g;
    logic [HB-1:0] m_idx;
    logic          m_pred;
    @(negedge clk);
    rst = r; if_pc = pc; lookup_valid = lv;
    upd_valid = uv; upd_index = ui; upd_ghr = ug; upd_taken = ut; upd_mispredict = um;
    #1;
    m_idx  = pc[HB+1:2] ^ m_ghr;
    m_pred = m_pht[m_idx][1];
    e.idx = m_idx; e.pred = m_pred; e.ghr = m_ghr;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    check("pred_index", 32'(pred_index), 32'(g.idx));
    check("global_prediction", 32'(global_prediction), 32'(g.pred));
    check("pred_ghr", 32'(pred_ghr), 32'(g.ghr));
    obs_pred = global_prediction; obs_idx = pred_index; obs_ghr = pred_ghr;
    @(posedge clk);
    if (r) begin
      m_ghr = '0;
      for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
    end else begin
      if (uv && um)  m_ghr = {ug[HB-2:0], ut};
      else if (lv)   m_ghr = {m_ghr[HB-2:0], m_pred};
      if (uv)        m_pht[ui] = model_sat(m_pht[ui], ut);
    end
  endtask

  // Look up a PC without shifting history or training.
  task automatic peek(input logic [31:0] pc);
    cycle(1'b0, pc, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  // Train one PHT entry with no lookup shift.
  task automatic train(input logic [HB-1:0] idx, input logic t);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, idx, 8'h00, t, 1'b0);
  endtask

  initial begin
    m_ghr = 'x;
    for (int i = 0; i < 256; i++) m_pht[i] = 2'bxx;
    rst = 1'b1; if_pc = '0; lookup_valid = 1'b0;
    upd_valid = 1'b0; upd_index = '0; upd_ghr = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;

    // 1. Reset with a concurrent lookup: the shift is suppressed.
    @(posedge clk);
    m_ghr = '0;
    for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
    cycle(1'b1, 32'h40, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("t1_idx", 32'(obs_idx), 32'h10);
    check("t1_pred", 32'(obs_pred), 32'h0);
    check("t1_ghr", 32'(obs_ghr), 32'h00);
    peek(32'h40);
    check("t1_ghr_next", 32'(obs_ghr), 32'h00);

    // 2. Two taken updates bring PHT[0x10] from 01 to 11.
    train(8'h10, 1'b1);
    train(8'h10, 1'b1);
    peek(32'h40);
    check("t2_pred", 32'(obs_pred), 32'h1);

    // 3. Saturation in both directions.
    train(8'h10, 1'b1);            // stays 11
    peek(32'h40);
    check("t3_sat_hi", 32'(obs_pred), 32'h1);
    train(8'h10, 1'b0);            // 10
    peek(32'h40);
    check("t3_wt", 32'(obs_pred), 32'h1);
    train(8'h10, 1'b0);            // 01
    train(8'h10, 1'b0);            // 00
    peek(32'h40);
    check("t3_snt", 32'(obs_pred), 32'h0);
    train(8'h10, 1'b0);            // stays 00
    train(8'h10, 1'b1);            // 01 only if it held at 00
    peek(32'h40);
    check("t3_sat_lo", 32'(obs_pred), 32'h0);

    // 4. History shift 1,1,0, then a same-cycle lookup and update to one index.
    train(8'h20, 1'b1);
    train(8'h31, 1'b1);
    cycle(1'b0, 32'h80,  1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);  // idx 0x20 -> 1
    cycle(1'b0, 32'hC0,  1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);  // idx 0x31 -> 1
    cycle(1'b0, 32'h140, 1'b1, 1'b1, 8'h53, 8'h00, 1'b1, 1'b0);  // idx 0x53, trained now
    check("t4_no_bypass", 32'(obs_pred), 32'h0);
    peek(32'h154);                                               // GHR 0x06 -> idx 0x53
    check("t4_ghr", 32'(obs_ghr), 32'h06);
    check("t4_idx", 32'(obs_idx), 32'h53);
    check("t4_new_ctr", 32'(obs_pred), 32'h1);

    // A mispredict flag without upd_valid is ignored.
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 8'hAA, 1'b1, 1'b1);
    peek(32'h0);
    check("t4_um_ignored", 32'(obs_ghr), 32'h06);

    // 5. Recovery overrides a concurrent lookup shift and still trains.
    cycle(1'b0, 32'h40, 1'b1, 1'b1, 8'h77, 8'h05, 1'b1, 1'b1);
    peek(32'h1F0);                                               // GHR 0x0B -> idx 0x77
    check("t5_ghr", 32'(obs_ghr), 32'h0B);
    check("t5_trained", 32'(obs_pred), 32'h1);

    // Random traffic against the model.
    for (int k = 0; k < 60; k++) begin
      cycle(1'b0, $urandom, 1'($urandom), 1'($urandom),
            8'($urandom_range(0, 15) * 17), 8'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) == 0));
    end

    // 6. Reset mid-operation wins over a concurrent update and lookup.
    cycle(1'b1, 32'h80, 1'b1, 1'b1, 8'h10, 8'hFF, 1'b1, 1'b1);
    peek(32'h40);
    check("t6_ghr", 32'(obs_ghr), 32'h00);
    check("t6_pred", 32'(obs_pred), 32'h0);
    peek(32'h80);
    check("t6_pht_cleared", 32'(obs_pred), 32'h0);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
